// File: rtl/weight_loader_if.sv
// -----------------------------------------------------------------------------
// weight_loader_if
// Purpose : Bundles the byte-stream handshake and the memory write port of the
//           weight loader so they travel as one connection.
// Signals : s_valid / s_data   - incoming stream byte and its valid flag
//           s_ready            - loader accepts the byte this cycle
//           wr_en              - one-cycle write strobe
//           wr_sel             - target memory: 0=w1, 1=b1, 2=w2, 3=b2
//           wr_addr / wr_data  - byte address within target and byte value
// Modports: slave  - the loader (consumes stream, produces writes)
//           master - the environment (produces stream, observes writes)
// -----------------------------------------------------------------------------
interface weight_loader_if;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;

  modport slave (
    input  s_valid, s_data,
    output s_ready, wr_en, wr_sel, wr_addr, wr_data
  );

  modport master (
    output s_valid, s_data,
    input  s_ready, wr_en, wr_sel, wr_addr, wr_data
  );
endinterface

// File: rtl/weight_loader.sv
// -----------------------------------------------------------------------------
// weight_loader
// Purpose : Streams a complete network weight image (W1, B1, W2, B2) from a
//           byte stream into four target memories, then checks a trailing
//           XOR checksum byte.
// Params  : N_IN, N_HID, N_OUT - layer widths that size the four sections.
// Ports   : clk    - single rising-edge clock
//           rst    - asynchronous active-low reset
//           start  - one-cycle load request (ignored while busy)
//           bus    - stream handshake + memory write port (slave modport)
//           busy   - load in progress (LD_W1..FIN)
//           done   - one-cycle pulse when the load finishes
//           err    - sticky checksum mismatch, cleared by the next start
// -----------------------------------------------------------------------------
module weight_loader #(
  parameter int N_IN  = 784,
  parameter int N_HID = 32,
  parameter int N_OUT = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  weight_loader_if.slave  bus,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam logic [14:0] LAST_W1 = 15'(N_IN * N_HID - 1);
  localparam logic [14:0] LAST_B1 = 15'(N_HID - 1);
  localparam logic [14:0] LAST_W2 = 15'(N_HID * N_OUT - 1);
  localparam logic [14:0] LAST_B2 = 15'(N_OUT - 1);

  typedef enum logic [2:0] {
    IDLE, LD_W1, LD_B1, LD_W2, LD_B2, CHK, FIN
  } state_t;

  state_t      state_q;
  logic [14:0] cnt_q;
  logic [7:0]  chk_q;
  logic        s_ready_q;
  logic        wr_en_q;
  logic [1:0]  wr_sel_q;
  logic [14:0] wr_addr_q;
  logic [7:0]  wr_data_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;

  // Per-section decode: which memory is targeted, whether the current
  // counter value is the section's final byte, and where to go next.
  logic        last_d;
  logic [1:0]  sel_d;
  state_t      adv_d;
  logic        xfer;

  assign xfer = bus.s_valid & s_ready_q;

  always_comb begin
    last_d = 1'b0;
    sel_d  = 2'd0;
    adv_d  = IDLE;
    case (state_q)
      LD_W1: begin last_d = (cnt_q == LAST_W1); sel_d = 2'd0; adv_d = LD_B1; end
      LD_B1: begin last_d = (cnt_q == LAST_B1); sel_d = 2'd1; adv_d = LD_W2; end
      LD_W2: begin last_d = (cnt_q == LAST_W2); sel_d = 2'd2; adv_d = LD_B2; end
      LD_B2: begin last_d = (cnt_q == LAST_B2); sel_d = 2'd3; adv_d = CHK;   end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      chk_q     <= '0;
      s_ready_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_sel_q  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // Strobes default low; write fields keep their last value.
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= LD_W1;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            chk_q     <= '0;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        LD_W1, LD_B1, LD_W2, LD_B2: begin
          if (xfer) begin
            wr_en_q   <= 1'b1;
            wr_sel_q  <= sel_d;
            wr_addr_q <= cnt_q;
            wr_data_q <= bus.s_data;
            chk_q     <= chk_q ^ bus.s_data;
            // The final byte of a section moves on in the same edge, so
            // the next section's first byte can arrive back-to-back.
            if (last_d) begin
              cnt_q   <= '0;
              state_q <= adv_d;
            end else begin
              cnt_q   <= cnt_q + 15'd1;
            end
          end
        end
        CHK: begin
          // Trailer byte is compared only, never written.
          if (xfer) begin
            if (bus.s_data != chk_q) err_q <= 1'b1;
            state_q   <= FIN;
            s_ready_q <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          s_ready_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_ready = s_ready_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_sel  = wr_sel_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 SHALL have parameter N_IN, default 784, input-layer width.
REQ-002 SHALL have parameter N_HID, default 32, hidden-layer width.
REQ-003 SHALL have parameter N_OUT, default 10, output-layer width.
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle load request.
REQ-007 SHALL have port s_valid  input  1  stream byte valid.
REQ-008 SHALL have port s_data  input  8  stream byte.
REQ-009 SHALL have port s_ready  output  1  loader accepts byte.
REQ-010 SHALL have port wr_en  output  1  memory write strobe.
REQ-011 SHALL have port wr_sel  output  2  target: 0=w1, 1=b1, 2=w2, 3=b2.
REQ-012 SHALL have port wr_addr  output  15  byte address within target.
REQ-013 SHALL have port wr_data  output  8  byte to write.
REQ-014 SHALL have port busy  output  1  load in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse, load finished.
REQ-016 SHALL have port err  output  1  sticky checksum-mismatch flag.

Function
REQ-017 Byte transfer SHALL occur on a cycle with s_valid=1 and s_ready=1; no other cycle consumes a byte.
REQ-018 FSM states SHALL be IDLE, LD_W1, LD_B1, LD_W2, LD_B2, CHK, FIN.
REQ-019 IDLE: start=1 SHALL go to LD_W1, clear err, zero address counter and checksum; otherwise stay.
REQ-020 LD_W1 SHALL accept N_IN*N_HID bytes (25088 default), addresses 0..N_IN*N_HID-1 in order, then go to LD_B1.
REQ-021 LD_B1 SHALL accept N_HID bytes, LD_W2 N_HID*N_OUT bytes (320), LD_B2 N_OUT bytes (10), each addressed from 0.
REQ-022 The address counter SHALL reset to 0 on each state change; last-byte transfer SHALL advance state in the same edge.
REQ-023 s_ready SHALL be 1 in LD_W1..CHK and 0 in IDLE and FIN.
REQ-024 Each accepted payload byte SHALL produce wr_en=1 exactly one cycle later, with wr_sel/wr_addr/wr_data registered from that transfer.
REQ-025 wr_en SHALL be 0 on all other cycles; wr_sel/wr_addr/wr_data SHALL hold their last value when wr_en=0.
REQ-026 Running checksum SHALL be 8-bit XOR of all payload bytes (W1..B2).
REQ-027 CHK SHALL accept one trailer byte, never written; mismatch with checksum SHALL set err; then go to FIN.
REQ-028 FIN SHALL assert done for exactly one cycle and return to IDLE next cycle.
REQ-029 busy SHALL be 1 in LD_W1..FIN and 0 in IDLE.
REQ-030 start while busy=1 SHALL be ignored.
REQ-031 s_valid gaps SHALL stall progress indefinitely without writes or state change.
REQ-032 err SHALL remain set through IDLE until the next accepted start.

Reset
REQ-033 rst=0 SHALL asynchronously force IDLE; s_ready, wr_en, busy, done, err, wr_sel, wr_addr, wr_data, counter and checksum all 0.
REQ-034 Reset mid-load SHALL discard the partial load; no write SHALL issue for a byte accepted in the cycle reset asserts.

Verification
REQ-035 start, then 25450 bytes of value (index mod 256) streaming continuously plus correct XOR trailer -> 25450 writes, sel/addr sequence w1 0..25087, b1 0..31, w2 0..319, b2 0..9, done pulse, err=0.
REQ-036 Same stream with trailer inverted -> identical writes, done pulse, err=1; err stays 1 until next start, cleared on that start.
REQ-037 s_valid toggled 1/0 every cycle through LD_B1 -> exactly 32 writes, addresses consecutive, no duplicates.
REQ-038 start pulsed during LD_W2 -> no restart, addresses continue uninterrupted.
REQ-039 rst=0 asserted after 100 W1 bytes -> all outputs 0 immediately; next start restarts at w1 address 0.
REQ-040 Bytes presented in IDLE with no start -> s_ready=0, no writes, busy=0.
